// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : apu_frame_sequencer                                     |
// | Desc     : APU frame counter; quarter/half-frame clocks and IRQ.   |
// |            Frame IRQ logic present only with APU_FRAME_IRQ_EN.     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module apu_frame_sequencer #(
  parameter int STEP1       = 7457,
  parameter int STEP2       = 14913,
  parameter int STEP3       = 22371,
  parameter int STEP4       = 29829,
  parameter int STEP5       = 37281,
  parameter int WRITE_DELAY = 3
) (
  input  logic       cpu_clk,
  input  logic       reset_n,
  input  logic       reg_write,
  input  logic [7:0] data_in,
  input  logic       status_read,
  output logic       quarter_clk,
  output logic       half_clk,
  output logic       half_toggle,
  output logic       frame_irq,
  output logic       mode_out
);

  localparam int                 c_dly_w = $clog2(WRITE_DELAY + 2);
  localparam logic [15:0]        c_step1 = 16'(STEP1);
  localparam logic [15:0]        c_step2 = 16'(STEP2);
  localparam logic [15:0]        c_step3 = 16'(STEP3);
  localparam logic [15:0]        c_step4 = 16'(STEP4);
  localparam logic [15:0]        c_step5 = 16'(STEP5);
  localparam logic [c_dly_w-1:0] c_delay = c_dly_w'(WRITE_DELAY);
  localparam logic [c_dly_w-1:0] c_one   = c_dly_w'(1);

  logic [15:0]        r_count;
  logic               r_mode;
  logic               r_inhibit;
  logic               r_parity;
  logic [c_dly_w-1:0] r_delay;
  logic               r_quarter;
  logic               r_half;
  logic               r_toggle;

  logic [15:0] w_final;
  logic        w_expire;
  logic        w_wrap;
  logic        w_quarter_hit;
  logic        w_half_hit;
  logic        w_quarter_ev;
  logic        w_half_ev;
  logic        w_unused;

  // A write on the expiry cycle re-arms instead of resetting.
  always_comb begin
    w_final       = r_mode ? c_step5 : c_step4;
    w_expire      = (r_delay == c_one) && !reg_write;
    w_wrap        = (r_count == w_final + 16'd1);
    w_quarter_hit = (r_count == c_step1) || (r_count == c_step2) ||
                    (r_count == c_step3) || (r_count == w_final);
    w_half_hit    = (r_count == c_step2) || (r_count == w_final);
    w_quarter_ev  = w_expire ? r_mode : w_quarter_hit;
    w_half_ev     = w_expire ? r_mode : w_half_hit;
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_mode    <= 1'b0;
      r_inhibit <= 1'b0;
      r_parity  <= 1'b0;
      r_delay   <= '0;
      r_quarter <= 1'b0;
      r_half    <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_parity  <= ~r_parity;
      r_quarter <= w_quarter_ev;
      r_half    <= w_half_ev;
      r_toggle  <= r_toggle ^ w_half_ev;
      if (w_expire || w_wrap) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 16'd1;
      end
      // Odd-parity writes wait one extra cycle.
      if (reg_write) begin
        r_mode    <= data_in[7];
        r_inhibit <= data_in[6];
        r_delay   <= c_delay + c_dly_w'(r_parity);
      end else if (r_delay != '0) begin
        r_delay <= r_delay - c_one;
      end
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic r_irq;
  logic r_nat_zero;
  logic w_irq_set;

  // Zero only counts toward the IRQ when reached by natural wrap.
  assign w_irq_set = !r_mode && !r_inhibit &&
                     ((r_count == c_step4) || (r_count == c_step4 + 16'd1) ||
                      ((r_count == '0) && r_nat_zero));

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq      <= 1'b0;
      r_nat_zero <= 1'b0;
    end else begin
      r_nat_zero <= w_wrap && !w_expire;
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (status_read || r_inhibit) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign frame_irq = r_irq;
  assign w_unused  = ^data_in[5:0];
`else
  assign frame_irq = 1'b0;
  assign w_unused  = ^{data_in[5:0], status_read, r_inhibit};
`endif

  assign quarter_clk = r_quarter;
  assign half_clk    = r_half;
  assign half_toggle = r_toggle;
  assign mode_out    = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_apu_frame_sequencer                                  |
// | Desc     : Self-checking bench; scaled instance vs reference model,|
// |            default instance vs closed-form idle frame timing.      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_apu_frame_sequencer;

  localparam int S1 = 745, S2 = 1491, S3 = 2237, S4 = 2983, S5 = 3728, WD = 3;
  localparam int D1 = 7457, D2 = 14913, D3 = 22371, D4 = 29829;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       cpu_clk     = 1'b0;
  logic       reset_n     = 1'b0;
  logic       reset_d_n   = 1'b0;
  logic       reg_write   = 1'b0;
  logic       status_read = 1'b0;
  logic [7:0] data_in     = 8'h00;
  logic       q_s, h_s, t_s, i_s, m_s;
  logic       q_d, h_d, t_d, i_d, m_d;

  int errors = 0;
  int checks = 0;
  int g_n    = 0;

  // Reference model: frame position, absolute time and scheduled reset time.
  int m_pos, m_cycle, m_reset_at;
  bit m_mode, m_inh, m_wrapped, m_q, m_h, m_tog, m_irq;

  always #5 cpu_clk = ~cpu_clk;

  apu_frame_sequencer #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5), .WRITE_DELAY(WD)
  ) dut_s (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .reg_write(reg_write), .data_in(data_in),
    .status_read(status_read), .quarter_clk(q_s), .half_clk(h_s),
    .half_toggle(t_s), .frame_irq(i_s), .mode_out(m_s)
  );

  apu_frame_sequencer dut_d (
    .cpu_clk(cpu_clk), .reset_n(reset_d_n), .reg_write(1'b0), .data_in(8'h00),
    .status_read(1'b0), .quarter_clk(q_d), .half_clk(h_d),
    .half_toggle(t_d), .frame_irq(i_d), .mode_out(m_d)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cycle = 0; m_reset_at = -1;
    m_mode = 0; m_inh = 0; m_wrapped = 0;
    m_q = 0; m_h = 0; m_tog = 0; m_irq = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [7:0] d, input bit rd);
    int fin;
    bit forced, n_q, n_h, set;
    fin    = m_mode ? S5 : S4;
    forced = (m_reset_at == m_cycle) && !wr;
    n_q    = forced ? m_mode : ((m_pos inside {S1, S2, S3}) || (m_pos == fin));
    n_h    = forced ? m_mode : ((m_pos == S2) || (m_pos == fin));
    set    = IRQ_EN && !m_mode && !m_inh &&
             ((m_pos == S4) || (m_pos == S4 + 1) || ((m_pos == 0) && m_wrapped));
    if (set) m_irq = 1;
    else if (rd || m_inh) m_irq = 0;
    m_wrapped = !forced && (m_pos == fin + 1);
    m_pos     = (forced || (m_pos == fin + 1)) ? 0 : (m_pos + 1) % 65536;
    m_q = n_q;
    m_h = n_h;
    if (n_h) m_tog = !m_tog;
    if (wr) begin
      m_reset_at = m_cycle + WD + (m_cycle % 2);
      m_mode     = d[7];
      m_inh      = d[6];
    end else if (forced) begin
      m_reset_at = -1;
    end
    m_cycle++;
  endtask

  task automatic compare_s();
    chk("quarter", q_s, m_q);
    chk("half", h_s, m_h);
    chk("toggle", t_s, m_tog);
    chk("irq", i_s, m_irq);
    chk("mode", m_s, m_mode);
  endtask

  // Idle default instance: position is simply edges since release modulo frame length.
  task automatic compare_d();
    int e, r, halves;
    e      = g_n - 1;
    r      = e % (D4 + 2);
    halves = 2 * (e / (D4 + 2)) + int'(r >= D2) + int'(r >= D4);
    chk("d_quarter", q_d, (r inside {D1, D2, D3, D4}));
    chk("d_half", h_d, (r == D2) || (r == D4));
    chk("d_toggle", t_d, halves[0]);
    chk("d_irq", i_d, IRQ_EN && (e >= D4));
    chk("d_mode", m_d, 1'b0);
  endtask

  task automatic step(input bit wr, input logic [7:0] d, input bit rd);
    reg_write = wr; data_in = d; status_read = rd;
    model_edge(wr, d, rd);
    @(posedge cpu_clk); #1;
    reg_write = 1'b0; status_read = 1'b0;
    g_n++;
    compare_s();
    compare_d();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic run_to(input int pos);
    int k;
    k = 0;
    while ((m_pos != pos) && (k < 8000)) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    if (k >= 8000) begin
      checks++;
      errors++;
      $error("FAIL run_to observed_pos=%0d expected_pos=%0d", m_pos, pos);
    end
  endtask

  initial begin
    bit wr_r, rd_r;
    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_quarter", q_s, 1'b0); chk("rst_half", h_s, 1'b0);
    chk("rst_toggle", t_s, 1'b0);  chk("rst_irq", i_s, 1'b0);
    chk("rst_mode", m_s, 1'b0);    chk("rst_d_quarter", q_d, 1'b0);
    chk("rst_d_irq", i_d, 1'b0);   chk("rst_d_mode", m_d, 1'b0);
    @(negedge cpu_clk);
    reset_n = 1'b1; reset_d_n = 1'b1;
    model_reset();

    // 4-step frames from reset
    run_to(S1); step(0, 8'h00, 0);
    chk("q_at_step1", q_s, 1'b1);
    idle(2 * (S4 + 2) - (S1 + 1));
    chk("tog_after_2_frames", t_s, 1'b0);
    chk("irq_after_2_frames", i_s, IRQ_EN);

    // status read on a set cycle, then on a quiet cycle
    run_to(S4 + 1); step(0, 8'h00, 1);
    chk("irq_read_vs_set", i_s, IRQ_EN);
    run_to(100); step(0, 8'h00, 1);
    chk("irq_read_clear", i_s, 1'b0);

    // 5-step write on even parity
    if (m_cycle % 2 != 0) step(0, 8'h00, 0);
    step(1, 8'h80, 0);
    chk("mode_after_write", m_s, 1'b1);
    idle(2);
    chk("q_before_even_rst", q_s, 1'b0);
    step(0, 8'h00, 0);
    chk("q_on_even_rst", q_s, 1'b1);
    chk("h_on_even_rst", h_s, 1'b1);
    run_to(S4); step(0, 8'h00, 0);
    chk("no_q_at_step4_5mode", q_s, 1'b0);
    chk("no_h_at_step4_5mode", h_s, 1'b0);
    run_to(S5); step(0, 8'h00, 0);
    chk("h_at_step5", h_s, 1'b1);
    idle(2);
    chk("irq_5mode", i_s, 1'b0);

    // 5-step write on odd parity
    if (m_cycle % 2 == 0) step(0, 8'h00, 0);
    step(1, 8'h80, 0);
    idle(2);
    step(0, 8'h00, 0);
    chk("q_before_odd_rst", q_s, 1'b0);
    step(0, 8'h00, 0);
    chk("q_on_odd_rst", q_s, 1'b1);

    // back to 4-step, then inhibit while flag is set
    step(1, 8'h00, 0);
    idle(5);
    run_to(S4); step(0, 8'h00, 0);
    chk("irq_rise", i_s, IRQ_EN);
    step(1, 8'h40, 0);
    step(0, 8'h00, 0);
    chk("irq_inhibit_clear", i_s, 1'b0);
    idle(2 * (S4 + 2));
    chk("irq_inhibited_frames", i_s, 1'b0);

    // reset mid-delay
    step(1, 8'h00, 0);
    idle(5);
    run_to(2000);
    step(1, 8'h80, 0);
    step(0, 8'h00, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_quarter", q_s, 1'b0); chk("mid_rst_half", h_s, 1'b0);
    chk("mid_rst_toggle", t_s, 1'b0);  chk("mid_rst_irq", i_s, 1'b0);
    chk("mid_rst_mode", m_s, 1'b0);
    @(posedge cpu_clk); #1;
    g_n++;
    compare_d();
    reset_n = 1'b1;
    model_reset();
    run_to(S1); step(0, 8'h00, 0);
    chk("q_step1_after_rst", q_s, 1'b1);
    idle(S4 + 2);

    // randomized traffic until the default instance has seen a full frame
    while (g_n < 29900) begin
      wr_r = ($urandom_range(0, 511) == 0);
      rd_r = ($urandom_range(0, 127) == 0);
      step(wr_r, 8'($urandom), rd_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
- Frame counter / sequencer for the APU.
- Counts CPU cycles and emits quarter-frame and half-frame clock events.
  - Quarter-frame events drive the envelopes and linear counter.
  - Half-frame events drive the length counters and sweeps.
- Raises the frame IRQ.
- Configured by CPU writes to $4017; its IRQ flag is cleared by $4015 reads.

Parameters:
- STEP1, 7457: CPU cycle of step 1 (quarter).
- STEP2, 14913: cycle of step 2 (quarter+half).
- STEP3, 22371: cycle of step 3 (quarter).
- STEP4, 29829: cycle of step 4 (quarter+half in 4-step mode; no event in 5-step mode).
- STEP5, 37281: cycle of step 5 (quarter+half, 5-step mode only).
- WRITE_DELAY, 3: base cycles from a $4017 write to the counter reset.

Ports:
- cpu_clk  in  1  CPU clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- reg_write  in  1  one-cycle strobe: CPU write to $4017.
- data_in  in  8  write data: [7]=mode (1=5-step), [6]=IRQ inhibit, others ignored.
- status_read  in  1  one-cycle strobe: CPU read of $4015.
- quarter_clk  out  1  one-cycle pulse per quarter-frame event.
- half_clk  out  1  one-cycle pulse per half-frame event.
- half_toggle  out  1  level that inverts on every half-frame event (toggle-style edge for length counters).
- frame_irq  out  1  frame interrupt flag.
- mode_out  out  1  current mode bit.

Behaviour:
- Reset (async, reset_n=0):
  - 16-bit cycle counter = 0; mode = 0; inhibit = 0; parity = 0; pending write cleared.
  - All outputs = 0.
  - Reset mid-frame or mid-delay aborts everything immediately.
- Parity bit toggles every cpu_clk.
- Counter:
  - Increments by 1 each cycle.
  - 4-step: after value STEP4+1 the next value is 0.
  - 5-step: after value STEP5+1 the next value is 0.
  - No other wrap; width 16 bits.
- Events, registered so outputs change the cycle after the counter equals the compare value (latency 1):
  - Quarter event when counter equals STEP1, STEP2, STEP3, or the final step (STEP4 in 4-step, STEP5 in 5-step).
  - Half event at STEP2 and at the final step.
  - quarter_clk and half_clk pulse high exactly 1 cycle.
  - half_toggle inverts in the same cycle half_clk pulses.
- $4017 write:
  - mode and inhibit registers load data_in[7:6] on the write cycle.
  - A pending reset arms with delay WRITE_DELAY if parity=0 at the write, WRITE_DELAY+1 if parity=1.
  - When the delay expires, the counter is forced to 0 that cycle; no compare events fire that cycle.
  - If the new mode=1, quarter_clk and half_clk pulse (and half_toggle inverts) on that reset cycle.
  - A second write while a reset is pending re-arms the delay using the new parity and data; only one reset occurs.
- Frame IRQ:
  - Sets when mode=0, inhibit=0, and counter is STEP4, STEP4+1, or 0 reached by natural wrap (not by forced reset).
  - Sticky.
  - Clears on status_read, or on the cycle after inhibit becomes 1.
  - Set and status_read in the same cycle: set wins.
  - Mode=1 never sets the flag.
  - A write with mode=1 but inhibit=0 leaves an existing flag set.
- Simultaneous reg_write and status_read: both take effect independently.

Optional Feature:
- Macro: APU_FRAME_IRQ_EN.
- Defined: frame IRQ logic present as described.
- Undefined: flag register omitted; frame_irq tied 0; status_read ignored; inhibit bit still stored but has no effect.

Test Plan:
- Release reset, idle, 4-step mode.
  - Required: quarter_clk at counter 7457, 14913, 22371, 29829 (each registered 1 cycle later).
  - Required: half_clk only at 14913 and 29829.
  - Required: half_toggle ends at 0 after 2 frames.
  - Required: frame_irq rises at 29829 and stays high.
- Write data_in=8'h80 on an even-parity cycle.
  - Required: counter forced to 0 three cycles later, with quarter_clk and half_clk pulsing that cycle.
  - Required: next half_clk at counter 14913, then 37281.
  - Required: no event at 29829; frame_irq stays 0.
- Same write on an odd-parity cycle -> reset occurs four cycles later.
- frame_irq high, then status_read pulse at counter 29830.
  - Required: flag stays set.
  - Required: a later status_read at counter 100 clears it the next cycle.
- Write data_in=8'h40 while frame_irq=1 -> frame_irq low the cycle after; no IRQ on subsequent frames.
- Assert reset_n=0 for 1 cycle mid-delay at counter 20000 -> all outputs 0 immediately; sequence restarts from 0 in 4-step mode.
